host_frame_arbiter: RTL and testbench

HOST_FRAME_ARBITER -- requirements
Module: host_frame_arbiter

---
 rtl/host_frame_arbiter_pkg.sv | 22 ++
 rtl/host_frame_arbiter_if.sv | 52 +++++
 rtl/host_frame_arbiter_frame_rr_pick.sv | 13 +
 rtl/host_frame_arbiter.sv | 132 +++++++++++++
 tb/tb_host_frame_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/host_frame_arbiter_pkg.sv
// Shared types and constants for the two-requester frame arbiter.
// Holds the FSM encoding, bus widths and the default frame length limit.
package host_frame_arbiter_pkg;

  localparam int DATA_W        = 9;
  localparam int TAG_W         = 48;
  localparam int FCNT_W        = 16;
  localparam int WCNT_W        = 11;
  localparam int MAX_WORDS_DEF = 2047;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Word counter stops at all-ones so an overlong frame can never wrap back to "head".
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/host_frame_arbiter_if.sv
// Bundle of requester inputs and merged-stream outputs of the frame arbiter.
// master = requester/consumer side, slave = the arbiter itself.
interface host_frame_arbiter_if;
  import host_frame_arbiter_pkg::*;

  logic              i_frame_ready0;
  logic              i_frame_ready1;
  logic [DATA_W-1:0] iv_data0;
  logic [DATA_W-1:0] iv_data1;
  logic              o_rd0;
  logic              o_rd1;
  logic [TAG_W-1:0]  iv_tsntag0;
  logic [TAG_W-1:0]  iv_tsntag1;
  logic              i_hit0;
  logic              i_hit1;
  logic              i_replication_flag0;
  logic              i_replication_flag1;
  logic              i_standardpkt_tsnpkt_flag0;
  logic              i_standardpkt_tsnpkt_flag1;

  logic [DATA_W-1:0] ov_data;
  logic              o_data_wr;
  logic [TAG_W-1:0]  ov_tsntag;
  logic              o_hit;
  logic              o_replication_flag;
  logic              o_standardpkt_tsnpkt_flag;
  logic              o_src;
  logic              o_len_err;
  logic [FCNT_W-1:0] ov_frame_cnt0;
  logic [FCNT_W-1:0] ov_frame_cnt1;

  modport master (
    output i_frame_ready0, i_frame_ready1, iv_data0, iv_data1,
           iv_tsntag0, iv_tsntag1, i_hit0, i_hit1,
           i_replication_flag0, i_replication_flag1,
           i_standardpkt_tsnpkt_flag0, i_standardpkt_tsnpkt_flag1,
    input  o_rd0, o_rd1, ov_data, o_data_wr, ov_tsntag, o_hit,
           o_replication_flag, o_standardpkt_tsnpkt_flag, o_src,
           o_len_err, ov_frame_cnt0, ov_frame_cnt1
  );

  modport slave (
    input  i_frame_ready0, i_frame_ready1, iv_data0, iv_data1,
           iv_tsntag0, iv_tsntag1, i_hit0, i_hit1,
           i_replication_flag0, i_replication_flag1,
           i_standardpkt_tsnpkt_flag0, i_standardpkt_tsnpkt_flag1,
    output o_rd0, o_rd1, ov_data, o_data_wr, ov_tsntag, o_hit,
           o_replication_flag, o_standardpkt_tsnpkt_flag, o_src,
           o_len_err, ov_frame_cnt0, ov_frame_cnt1
  );

endinterface

// File: rtl/host_frame_arbiter_frame_rr_pick.sv
// Combinational 2-way round-robin picker: when both requesters are ready,
// the one that was not served last wins.
module frame_rr_pick (
  input  logic [1:0] i_ready,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_sel
);

  assign o_valid = |i_ready;
  assign o_sel   = (&i_ready) ? ~i_last : i_ready[1];

endmodule

// File: rtl/host_frame_arbiter.sv
// Merges two FWFT frame buffers into one 9-bit stream, one whole frame at a time,
// with round-robin grants, a one-cycle inter-frame gap and a frame length guard.
module host_frame_arbiter
  import host_frame_arbiter_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input logic                i_clk,
  input logic                i_rst,
  host_frame_arbiter_if.slave bus
);

  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(MAX_WORDS - 1);

  arb_state_t        r_state;
  logic              r_sel;
  logic              r_last;
  logic [WCNT_W-1:0] r_wcnt;
  logic [DATA_W-1:0] r_data;
  logic              r_data_wr;
  logic [TAG_W-1:0]  r_tsntag;
  logic              r_hit;
  logic              r_repl;
  logic              r_std;
  logic              r_src;
  logic              r_len_err;
  logic [FCNT_W-1:0] r_frame_cnt0;
  logic [FCNT_W-1:0] r_frame_cnt1;

  logic              w_grant;
  logic              w_pick;
  logic              w_reading;
  logic [DATA_W-1:0] w_head;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_repl;
  logic              w_std;
  logic              w_tail;
  logic              w_guard;

  frame_rr_pick u_pick (
    .i_ready ({bus.i_frame_ready1, bus.i_frame_ready0}),
    .i_last  (r_last),
    .o_valid (w_grant),
    .o_sel   (w_pick)
  );

  assign w_reading = (r_state == READ);
  assign w_head    = r_sel ? bus.iv_data1 : bus.iv_data0;
  assign w_tag     = r_sel ? bus.iv_tsntag1 : bus.iv_tsntag0;
  assign w_hit     = r_sel ? bus.i_hit1 : bus.i_hit0;
  assign w_repl    = r_sel ? bus.i_replication_flag1 : bus.i_replication_flag0;
  assign w_std     = r_sel ? bus.i_standardpkt_tsnpkt_flag1 : bus.i_standardpkt_tsnpkt_flag0;

  // bit8 on the first word marks the head, so only a later bit8 word closes the frame.
  assign w_tail  = w_head[DATA_W-1] && (r_wcnt != '0);
  assign w_guard = !w_tail && (r_wcnt == LAST_IDX);

  assign bus.o_rd0 = w_reading && !r_sel;
  assign bus.o_rd1 = w_reading && r_sel;

  assign bus.ov_data                   = r_data;
  assign bus.o_data_wr                 = r_data_wr;
  assign bus.ov_tsntag                 = r_tsntag;
  assign bus.o_hit                     = r_hit;
  assign bus.o_replication_flag        = r_repl;
  assign bus.o_standardpkt_tsnpkt_flag = r_std;
  assign bus.o_src                     = r_src;
  assign bus.o_len_err                 = r_len_err;
  assign bus.ov_frame_cnt0             = r_frame_cnt0;
  assign bus.ov_frame_cnt1             = r_frame_cnt1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_last       <= 1'b1;
      r_wcnt       <= '0;
      r_data       <= '0;
      r_data_wr    <= 1'b0;
      r_tsntag     <= '0;
      r_hit        <= 1'b0;
      r_repl       <= 1'b0;
      r_std        <= 1'b0;
      r_src        <= 1'b0;
      r_len_err    <= 1'b0;
      r_frame_cnt0 <= '0;
      r_frame_cnt1 <= '0;
    end else begin
      r_data_wr <= 1'b0;
      r_len_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_sel   <= w_pick;
            r_wcnt  <= '0;
            r_state <= READ;
          end
        end
        READ: begin
          r_data_wr <= 1'b1;
          r_data    <= {w_head[DATA_W-1] | w_guard, w_head[DATA_W-2:0]};
          r_wcnt    <= sat_inc(r_wcnt);
          if (r_wcnt == '0) begin
            r_tsntag <= w_tag;
            r_hit    <= w_hit;
            r_repl   <= w_repl;
            r_std    <= w_std;
            r_src    <= r_sel;
          end
          if (w_tail) begin
            r_last  <= r_sel;
            r_state <= GAP;
            if (r_sel) r_frame_cnt1 <= r_frame_cnt1 + 1'b1;
            else       r_frame_cnt0 <= r_frame_cnt0 + 1'b1;
          end else if (w_guard) begin
            r_len_err <= 1'b1;
            r_last    <= r_sel;
            r_state   <= GAP;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_frame_arbiter.sv
// Directed bench for host_frame_arbiter: single frame, contention, late request,
// length guard (second instance with MAX_WORDS=16), mid-frame reset, counter wrap.
module tb_host_frame_arbiter;
  import host_frame_arbiter_pkg::*;

  typedef struct {
    int         c;
    logic       s;
    logic [8:0] d;
  } outRec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  host_frame_arbiter_if bigIf ();
  host_frame_arbiter_if smallIf ();

  host_frame_arbiter #(.MAX_WORDS(2047)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bigIf)
  );

  host_frame_arbiter #(.MAX_WORDS(16)) dutSmall (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (smallIf)
  );

  logic [8:0] fifo0[$];
  logic [8:0] fifo1[$];
  logic [8:0] fifoS[$];
  bit         en0, en1, enS;
  bit         p0, p1, pS;
  int         cyc = 0;
  int         totalChecks = 0;
  int         badChecks = 0;

  outRec_t    outQ[$];
  outRec_t    smallQ[$];
  int         bigLenErr = 0;
  int         smallLenErr = 0;
  int         lenErrCyc = -1;
  int         cntAtErr = -1;
  int         bothRd = 0;
  int         firstRd1 = -1;

  int         fFirstC[$];
  int         fLastC[$];
  int         fLen[$];
  logic       fSrc[$];
  logic [8:0] fHead[$];
  logic [8:0] fLastD[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    bigIf.iv_data0       = (fifo0.size() > 0) ? fifo0[0] : 9'h000;
    bigIf.iv_data1       = (fifo1.size() > 0) ? fifo1[0] : 9'h000;
    bigIf.i_frame_ready0 = en0 && (fifo0.size() > 0);
    bigIf.i_frame_ready1 = en1 && (fifo1.size() > 0);
    smallIf.iv_data0       = (fifoS.size() > 0) ? fifoS[0] : 9'h000;
    smallIf.i_frame_ready0 = enS && (fifoS.size() > 0);
    smallIf.iv_data1       = 9'h000;
    smallIf.i_frame_ready1 = 1'b0;
  endtask

  // Builds a frame: head carries headByte, middles carry their index, last word tailByte.
  task automatic applyStimulus(input int req, input int len, input logic [7:0] headByte,
                               input logic [7:0] tailByte, input bit withTail);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      if (i == 0)            w = {1'b1, headByte};
      else if (i == len - 1) w = {withTail, tailByte};
      else                   w = {1'b0, 8'(i)};
      case (req)
        0:       fifo0.push_back(w);
        1:       fifo1.push_back(w);
        default: fifoS.push_back(w);
      endcase
    end
    refresh();
  endtask

  task automatic doReset();
    rst = 1'b1;
    en0 = 1'b0; en1 = 1'b0; enS = 1'b0;
    repeat (2) @(negedge clk);
    fifo0.delete(); fifo1.delete(); fifoS.delete();
    outQ.delete(); smallQ.delete();
    smallLenErr = 0; lenErrCyc = -1; cntAtErr = -1; firstRd1 = -1;
    refresh();
    rst = 1'b0;
    #1;
  endtask

  task automatic waitWords(input bit useSmall, input int n, input string tag);
    int k = 0;
    while (((useSmall ? smallQ.size() : outQ.size()) < n) && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (4) begin @(negedge clk); #1; end
    checkOutput({tag, "_words"}, useSmall ? smallQ.size() : outQ.size(), n);
  endtask

  // Output words in consecutive cycles belong to the same frame.
  task automatic splitFrames(input bit useSmall);
    outRec_t q[$];
    int      last;
    if (useSmall) q = smallQ;
    else          q = outQ;
    fFirstC.delete(); fLastC.delete(); fLen.delete();
    fSrc.delete(); fHead.delete(); fLastD.delete();
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0 || q[i].c != q[i-1].c + 1) begin
        fFirstC.push_back(q[i].c);
        fLastC.push_back(q[i].c);
        fLen.push_back(1);
        fSrc.push_back(q[i].s);
        fHead.push_back(q[i].d);
        fLastD.push_back(q[i].d);
      end else begin
        last = fLen.size() - 1;
        fLen[last]   = fLen[last] + 1;
        fLastC[last] = q[i].c;
        fLastD[last] = q[i].d;
      end
    end
  endtask

  always @(negedge clk) begin
    p0 = bigIf.o_rd0;
    p1 = bigIf.o_rd1;
    pS = smallIf.o_rd0;
    if (bigIf.o_data_wr)   outQ.push_back('{cyc, bigIf.o_src, bigIf.ov_data});
    if (smallIf.o_data_wr) smallQ.push_back('{cyc, smallIf.o_src, smallIf.ov_data});
    if (bigIf.o_len_err) bigLenErr++;
    if (smallIf.o_len_err) begin
      smallLenErr++;
      lenErrCyc = cyc;
      cntAtErr  = int'(smallIf.ov_frame_cnt0);
    end
    if (bigIf.o_rd0 && bigIf.o_rd1) bothRd++;
    if (bigIf.o_rd1 && firstRd1 < 0) firstRd1 = cyc;
  end

  // Pops land just after the edge that consumed the head word.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (p0 && fifo0.size() > 0) void'(fifo0.pop_front());
    if (p1 && fifo1.size() > 0) void'(fifo1.pop_front());
    if (pS && fifoS.size() > 0) void'(fifoS.pop_front());
    refresh();
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    badChecks++;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         startCyc;
    int         k;
    logic [7:0] hb;

    bigIf.iv_tsntag0 = 48'h123456789ABC;
    bigIf.iv_tsntag1 = 48'hCAFE0000BEEF;
    bigIf.i_hit0 = 1'b1; bigIf.i_replication_flag0 = 1'b0; bigIf.i_standardpkt_tsnpkt_flag0 = 1'b1;
    bigIf.i_hit1 = 1'b0; bigIf.i_replication_flag1 = 1'b1; bigIf.i_standardpkt_tsnpkt_flag1 = 1'b0;
    smallIf.iv_tsntag0 = 48'h0000000000AA;
    smallIf.iv_tsntag1 = '0;
    smallIf.i_hit0 = 1'b0; smallIf.i_replication_flag0 = 1'b0; smallIf.i_standardpkt_tsnpkt_flag0 = 1'b0;
    smallIf.i_hit1 = 1'b0; smallIf.i_replication_flag1 = 1'b0; smallIf.i_standardpkt_tsnpkt_flag1 = 1'b0;
    refresh();

    // Single 64-word frame from requester 0, plus reset-state checks.
    doReset();
    checkOutput("rst_data",    bigIf.ov_data, 0);
    checkOutput("rst_wr",      bigIf.o_data_wr, 0);
    checkOutput("rst_tag",     bigIf.ov_tsntag, 0);
    checkOutput("rst_flags",   {bigIf.o_hit, bigIf.o_replication_flag, bigIf.o_standardpkt_tsnpkt_flag}, 0);
    checkOutput("rst_src",     bigIf.o_src, 0);
    checkOutput("rst_lenerr",  bigIf.o_len_err, 0);
    checkOutput("rst_cnt",     {bigIf.ov_frame_cnt1, bigIf.ov_frame_cnt0}, 0);
    checkOutput("rst_rd",      {bigIf.o_rd1, bigIf.o_rd0}, 0);
    applyStimulus(0, 64, 8'hAA, 8'h55, 1'b1);
    startCyc = cyc;
    en0 = 1'b1;
    refresh();
    waitWords(1'b0, 64, "single");
    // Ready sampled at edge startCyc+1; first word is visible after edge startCyc+2.
    checkOutput("single_latency", outQ[0].c, startCyc + 2);
    checkOutput("single_head",    outQ[0].d, 9'h1AA);
    checkOutput("single_mid",     outQ[10].d, 9'h00A);
    checkOutput("single_tail",    outQ[63].d, 9'h155);
    checkOutput("single_contig",  outQ[63].c - outQ[0].c, 63);
    checkOutput("single_tag",     bigIf.ov_tsntag, 48'h123456789ABC);
    checkOutput("single_flags",   {bigIf.o_hit, bigIf.o_replication_flag, bigIf.o_standardpkt_tsnpkt_flag}, 3'b101);
    checkOutput("single_src",     outQ[0].s, 0);
    checkOutput("single_cnt0",    bigIf.ov_frame_cnt0, 1);
    checkOutput("single_cnt1",    bigIf.ov_frame_cnt1, 0);

    // Both requesters hold 3 frames each and stay ready.
    doReset();
    for (int f = 0; f < 3; f++) begin
      applyStimulus(0, 4, 8'(16 * f), 8'hE0, 1'b1);
      applyStimulus(1, 4, 8'(8'h80 + 16 * f), 8'hE1, 1'b1);
    end
    en0 = 1'b1; en1 = 1'b1;
    refresh();
    waitWords(1'b0, 24, "cont");
    splitFrames(1'b0);
    checkOutput("cont_frames", fLen.size(), 6);
    for (int j = 0; j < 6 && j < fLen.size(); j++) begin
      hb = 8'((j % 2) * 128 + (j / 2) * 16);
      checkOutput($sformatf("cont_src%0d", j), fSrc[j], j % 2);
      checkOutput($sformatf("cont_head%0d", j), fHead[j], {1'b1, hb});
      checkOutput($sformatf("cont_len%0d", j), fLen[j], 4);
      if (j > 0) checkOutput($sformatf("cont_gap%0d", j), fFirstC[j] - fLastC[j-1], 3);
    end
    checkOutput("cont_cnt0", bigIf.ov_frame_cnt0, 3);
    checkOutput("cont_cnt1", bigIf.ov_frame_cnt1, 3);

    // Requester 1 becomes ready only after requester 0 is already being read.
    doReset();
    applyStimulus(0, 8, 8'h40, 8'h47, 1'b1);
    applyStimulus(1, 4, 8'hC0, 8'hC3, 1'b1);
    en0 = 1'b1;
    refresh();
    k = 0;
    while (!bigIf.o_rd0 && k < 50) begin @(negedge clk); #1; k++; end
    checkOutput("late_rd0_seen", bigIf.o_rd0, 1);
    en1 = 1'b1;
    refresh();
    waitWords(1'b0, 12, "late");
    splitFrames(1'b0);
    checkOutput("late_frames", fLen.size(), 2);
    if (fLen.size() == 2) begin
      checkOutput("late_src0", fSrc[0], 0);
      checkOutput("late_len0", fLen[0], 8);
      checkOutput("late_src1", fSrc[1], 1);
      checkOutput("late_head1", fHead[1], 9'h1C0);
      checkOutput("late_rd1_time", firstRd1, fLastC[0] + 2);
    end

    // Length guard on the MAX_WORDS=16 instance: 20 words, tail only on word 19.
    doReset();
    applyStimulus(2, 20, 8'h00, 8'h13, 1'b1);
    enS = 1'b1;
    refresh();
    waitWords(1'b1, 20, "guard");
    splitFrames(1'b1);
    checkOutput("guard_frames", fLen.size(), 2);
    if (fLen.size() == 2) begin
      checkOutput("guard_len0",   fLen[0], 16);
      checkOutput("guard_last0",  fLastD[0], 9'h10F);
      checkOutput("guard_errcyc", lenErrCyc, fLastC[0]);
      checkOutput("guard_len1",   fLen[1], 4);
      checkOutput("guard_head1",  fHead[1], 9'h010);
      checkOutput("guard_tail1",  fLastD[1], 9'h113);
    end
    checkOutput("guard_errcount", smallLenErr, 1);
    checkOutput("guard_cnt_at_err", cntAtErr, 0);
    checkOutput("guard_cnt_final", smallIf.ov_frame_cnt0, 1);

    // Reset asserted while requester 0 is mid-frame.
    doReset();
    applyStimulus(0, 32, 8'h20, 8'h3F, 1'b1);
    en0 = 1'b1;
    refresh();
    k = 0;
    while (outQ.size() < 10 && k < 100) begin @(negedge clk); #1; k++; end
    checkOutput("mrst_reached", outQ.size(), 10);
    checkOutput("mrst_pre_wr", bigIf.o_data_wr, 1);
    rst = 1'b1;
    #1;
    checkOutput("mrst_wr",   bigIf.o_data_wr, 0);
    checkOutput("mrst_rd",   {bigIf.o_rd1, bigIf.o_rd0}, 0);
    checkOutput("mrst_data", bigIf.ov_data, 0);
    checkOutput("mrst_tag",  bigIf.ov_tsntag, 0);
    checkOutput("mrst_misc", {bigIf.o_hit, bigIf.o_replication_flag, bigIf.o_standardpkt_tsnpkt_flag,
                              bigIf.o_src, bigIf.o_len_err}, 0);
    checkOutput("mrst_cnt",  {bigIf.ov_frame_cnt1, bigIf.ov_frame_cnt0}, 0);
    doReset();
    applyStimulus(0, 4, 8'h30, 8'h33, 1'b1);
    applyStimulus(1, 4, 8'hB0, 8'hB3, 1'b1);
    en0 = 1'b1; en1 = 1'b1;
    refresh();
    waitWords(1'b0, 8, "mrst_after");
    splitFrames(1'b0);
    checkOutput("mrst_frames", fLen.size(), 2);
    if (fLen.size() == 2) begin
      checkOutput("mrst_first_src",  fSrc[0], 0);
      checkOutput("mrst_first_head", fHead[0], 9'h130);
      checkOutput("mrst_second_src", fSrc[1], 1);
    end

    // Frame counter wrap for requester 1.
    doReset();
    force dut.r_frame_cnt1 = 16'hFFFF;
    #1;
    release dut.r_frame_cnt1;
    #1;
    checkOutput("wrap_preload", bigIf.ov_frame_cnt1, 16'hFFFF);
    applyStimulus(1, 4, 8'h90, 8'h93, 1'b1);
    en1 = 1'b1;
    refresh();
    waitWords(1'b0, 4, "wrap");
    checkOutput("wrap_src",  outQ[0].s, 1);
    checkOutput("wrap_tag",  bigIf.ov_tsntag, 48'hCAFE0000BEEF);
    checkOutput("wrap_cnt1", bigIf.ov_frame_cnt1, 16'h0000);
    checkOutput("wrap_cnt0", bigIf.ov_frame_cnt0, 16'h0000);

    checkOutput("never_both_rd",  bothRd, 0);
    checkOutput("big_no_len_err", bigLenErr, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
